// File: rtl/handshake_burst_requester.sv
// ---------------------------------------------------------------------------
// handshake_burst_requester
//
// Upstream half of the request/accept/done handshake. Incoming words are
// buffered in a small FIFO. While words are waiting, the block raises
// `request` for one burst of up to MAX_BURST words. It pops one word per
// cycle in which the controller holds `accept`, then waits for the
// controller's `done` pulse before it starts the next burst.
//
// Parameters
//   DATA_W     width of buffered words
//   DEPTH      FIFO entries (power of two, >= 2)
//   MAX_BURST  words per burst, 1..DEPTH
//   TIMEOUT    stall cycles before timeout_err (timeout build only)
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid/in_ready     upstream push handshake; in_ready = !full
//   in_data               upstream word
//   accept                controller is accepting words
//   done                  controller's one-cycle burst-complete pulse
//   request               a burst is in progress (state REQ)
//   out_valid/out_data    word transferred this cycle / FIFO head
//   level                 FIFO occupancy
//   busy                  FSM not idle
//   burst_done            done observed while waiting for it
//   timeout_err           sticky stall error
//
// Build option
//   HS_REQ_TIMEOUT_EN : when defined, a stall counter aborts a burst that
//   sees no progress for TIMEOUT cycles and sets timeout_err. When not
//   defined, timeout_err is tied low and the FSM waits indefinitely.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module handshake_burst_requester #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   accept,
    input  logic                   done,
    output logic                   request,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   burst_done,
    output logic                   timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(MAX_BURST) + 1;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_MAXB = (AW+1)'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RW-1:0]     rem;
    logic [RW-1:0]     rem_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              push;
    logic              pop;

    // Full is taken from the registered level only, so a pop in the same
    // cycle never opens room for a push while full.
    assign full       = (level == LVL_FULL);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign request    = (state == REQ);
    assign out_valid  = request && accept;
    assign pop        = out_valid;
    assign out_data   = mem[rd_ptr];
    assign busy       = (state != IDLE);
    assign burst_done = done && (state == WAIT_DONE);

    // Storage carries no reset; validity is tracked by the pointers/level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally at DEPTH; the extra level bit separates
    // full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: ;
            endcase
        end
    end

`ifdef HS_REQ_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] stall_nxt;
    logic          err_q;
    logic          err_set;
`endif

    // Burst length is latched once on leaving IDLE; words arriving during
    // the burst wait for the next one. Because rem <= level at latch time
    // and nothing else pops, the FIFO cannot run dry in REQ.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
`ifdef HS_REQ_TIMEOUT_EN
        stall_nxt = '0;
        err_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (level != '0) begin
                    rem_nxt   = (level > LVL_MAXB) ? RW'(MAX_BURST) : level[RW-1:0];
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (accept) begin
                    rem_nxt = rem - RW'(1);
                    if (rem == RW'(1)) begin
                        state_nxt = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef HS_REQ_TIMEOUT_EN
        // Any cycle without progress counts; the TIMEOUT-th one aborts the
        // burst and leaves unsent words in the FIFO.
        if ((state == REQ && !accept) || (state == WAIT_DONE && !done)) begin
            if (stall_cnt == SW'(TIMEOUT - 1)) begin
                err_set   = 1'b1;
                state_nxt = IDLE;
            end else begin
                stall_nxt = stall_cnt + SW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

`ifdef HS_REQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            stall_cnt <= stall_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_timeout;

    assign timeout_err    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_handshake_burst_requester.sv
`timescale 1ns/1ps

module tb_handshake_burst_requester;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int TIMEOUT   = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              accept;
    logic              done;
    logic              request;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        level;
    logic              busy;
    logic              burst_done;
    logic              timeout_err;

    handshake_burst_requester #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .MAX_BURST(MAX_BURST),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .accept     (accept),
        .done       (done),
        .request    (request),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .level      (level),
        .busy       (busy),
        .burst_done (burst_done),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    int              n_checks = 0;
    int              n_errors = 0;
    logic [7:0]      src_q[$];
    logic [7:0]      exp_q[$];
    int              bursts_q[$];
    int              lvl_m = 0;
    int              lvl_prev = 0;
    int              exp_n = 0;
    int              run_len = 0;
    int              xfer = 0;
    int              since_fall = 0;
    int              both_cnt = 0;
    bit              req_prev = 0;
    bit              waiting_m = 0;
    bit              expect_req = 0;
    bit              clean = 0;
    bit              exp_err = 0;
    bit              model_off = 0;
    bit              ctrl_en = 1;
    bit              hold_done = 0;
    bit              gap_en = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        src_q.delete();
        exp_q.delete();
        lvl_m      = 0;
        lvl_prev   = 0;
        req_prev   = 0;
        waiting_m  = 0;
        expect_req = 0;
        since_fall = 0;
        exp_err    = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        accept   = 1'b0;
        done     = 1'b0;
        #1;
        check("rst_level", level, 0);
        check("rst_request", request, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        check("rst_hold_level", level, 0);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: sample registered outputs at the falling edge, drive
    // the controller model and the source, then check combinational outputs.
    task automatic tick();
        bit req_now;
        bit rose;
        bit fell;
        bit pushed;
        bit popped;
        bit idle_now;
        @(negedge clk);
        req_now = request;
        rose    = req_now && !req_prev;
        fell    = !req_now && req_prev;
        if (!model_off) begin
            if (rose) begin
                exp_n   = (lvl_prev < MAX_BURST) ? lvl_prev : MAX_BURST;
                run_len = 0;
                xfer    = 0;
                clean   = ctrl_en;
            end
            if (fell) begin
                check("burst_words", xfer, exp_n);
                if (clean) check("req_cycles", run_len, exp_n + 1);
                bursts_q.push_back(xfer);
                waiting_m  = 1'b1;
                since_fall = 0;
            end else if (waiting_m) begin
                since_fall++;
            end
            if (expect_req) check("req_rise", req_now, 1);
            check("busy", busy, req_now || waiting_m);
            if (req_now) begin
                check("level_nz_in_req", level != '0, 1);
                run_len++;
                if (!ctrl_en) clean = 1'b0;
            end
        end
        check("level", level, lvl_m);
        check("in_ready", in_ready, lvl_m != DEPTH);
        check("timeout_err", timeout_err, exp_err);

        // Controller model: accept trails request by one cycle, done two
        // cycles after request falls.
        accept = ctrl_en && req_prev;
        done   = ctrl_en && !hold_done && waiting_m && (since_fall >= 2);
        if (src_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
            in_valid = 1'b1;
            in_data  = src_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
        #1;
        check("burst_done", burst_done, done);
        popped = out_valid;
        if (!req_now) check("no_xfer_req_low", out_valid, 0);
        if (popped) begin
            if (exp_q.size() == 0) check("out_valid_extra", out_valid, 0);
            else check("out_data", out_data, exp_q.pop_front());
            xfer++;
        end
        pushed = in_valid && (lvl_m != DEPTH);
        if (pushed) begin
            exp_q.push_back(in_data);
            void'(src_q.pop_front());
        end
        if (pushed && popped) both_cnt++;
        idle_now   = !req_now && !waiting_m;
        expect_req = !model_off && idle_now && (lvl_m > 0);
        lvl_prev   = lvl_m;
        lvl_m      = lvl_m + (pushed ? 1 : 0) - (popped ? 1 : 0);
        if (done) waiting_m = 1'b0;
        req_prev = req_now;
    endtask

    // Send one marker word and park its burst in WAIT_DONE by withholding done.
    task automatic hold_with_marker(input string tag);
        int cnt;
        hold_done = 1'b1;
        src_q.push_back(8'hEE);
        cnt = 0;
        while (!(waiting_m && src_q.size() == 0) && cnt < 30) begin
            tick();
            cnt++;
        end
        check({tag, "_parked"}, {30'd0, busy, request}, 32'd2);
        bursts_q.delete();
    endtask

    task automatic release_and_drain(input string tag, input int limit);
        int cnt;
        hold_done = 1'b0;
        cnt = 0;
        while (!(src_q.size() == 0 && lvl_m == 0 && !req_prev && !waiting_m) && cnt < limit) begin
            tick();
            cnt++;
        end
        tick();
        check({tag, "_idle"}, busy, 0);
        check({tag, "_empty"}, level, 0);
        check({tag, "_sb_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        accept   = 1'b0;
        done     = 1'b0;
        apply_reset();

        // Reset in the middle of a stalled burst with three words buffered
        ctrl_en = 1'b0;
        src_q.push_back(8'h11);
        src_q.push_back(8'h12);
        src_q.push_back(8'h13);
        repeat (5) tick();
        check("t1_level_before", level, 3);
        check("t1_request_before", request, 1);
        apply_reset();
        tick();
        check("t1_request_after", request, 0);
        ctrl_en = 1'b1;

        // Three words gathered while the previous burst waits for done
        hold_with_marker("t2");
        src_q.push_back(8'hA1);
        src_q.push_back(8'hA2);
        src_q.push_back(8'hA3);
        cnt = 0;
        while (src_q.size() > 0 && cnt < 10) begin
            tick();
            cnt++;
        end
        release_and_drain("t2", 60);
        check("t2_nbursts", bursts_q.size(), 1);
        if (bursts_q.size() >= 1) check("t2_burst0", bursts_q[0], 3);

        // Six words split by MAX_BURST into 4 + 2
        hold_with_marker("t3");
        for (int i = 0; i < 6; i++) src_q.push_back(8'h30 + 8'(i));
        cnt = 0;
        while (src_q.size() > 0 && cnt < 12) begin
            tick();
            cnt++;
        end
        release_and_drain("t3", 80);
        check("t3_nbursts", bursts_q.size(), 2);
        if (bursts_q.size() >= 2) begin
            check("t3_burst0", bursts_q[0], 4);
            check("t3_burst1", bursts_q[1], 2);
        end

        // Fill to full with a ninth word pending, then drain while pushing
        hold_with_marker("t4");
        for (int i = 0; i < 9; i++) src_q.push_back(8'h40 + 8'(i));
        repeat (10) tick();
        check("t4_full_level", level, DEPTH);
        check("t4_full_in_ready", in_ready, 0);
        check("t4_pending", src_q.size(), 1);
        for (int i = 0; i < 6; i++) src_q.push_back(8'h50 + 8'(i));
        both_cnt = 0;
        release_and_drain("t4", 120);
        check("t4_push_pop_seen", both_cnt > 0, 1);

        // Pointer wrap with random upstream gaps
        gap_en = 1'b1;
        for (int i = 0; i < 20; i++) src_q.push_back(8'($urandom));
        release_and_drain("t5", 600);
        gap_en = 1'b0;

`ifdef HS_REQ_TIMEOUT_EN
        // Controller never responds: timeout after TIMEOUT stall cycles
        ctrl_en   = 1'b0;
        model_off = 1'b1;
        src_q.push_back(8'h5A);
        cnt = 0;
        while (!req_prev && cnt < 10) begin
            tick();
            cnt++;
        end
        check("t6_request_seen", request, 1);
        repeat (TIMEOUT - 1) tick();
        exp_err = 1'b1;
        tick();
        check("t6_request_dropped", request, 0);
        check("t6_idle", busy, 0);
        check("t6_word_kept", level, 1);
        repeat (5) tick();
        check("t6_sticky", timeout_err, 1);
        apply_reset();
        model_off = 1'b0;
        ctrl_en   = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
